adder_accumulator: RTL and testbench

- Sequential front end for the adder datapath. Accepts a stream of DATA_WIDTH-bit operands through a valid/ready handshake.
- Sums exactly NUM_OPERANDS operands using an instantiated N-bit ripple adder. Keeps a sticky overflow flag across the pass.
- Presents the final sum with a one-cycle done pulse. Downstream logic consumes sum/overflow.

---
 rtl/accum_pkg.sv | 12 +
 rtl/adder_nbit.sv | 25 ++
 rtl/adder_accumulator.sv | 109 ++++++++++
 tb/tb_adder_accumulator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and defaults for the adder accumulator.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 4;

endpackage

// File: rtl/adder_nbit.sv
// Parameterized combinational ripple-carry adder; overflow is the final carry-out.
module adder_nbit
    import accum_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign overflow = carry[WIDTH];

endmodule

// File: rtl/adder_accumulator.sv
// Handshaked accumulator summing NUM_OPERANDS operands per pass with sticky overflow.
// Optional macro ACCUM_SATURATE_EN clamps sum to all ones on carry-out.
module adder_accumulator
    import accum_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter  int unsigned NUM_OPERANDS = 4,
    localparam int unsigned CNT_W        = $clog2(NUM_OPERANDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  overflow,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    accum_state_t          state, next_state;
    logic [DATA_WIDTH-1:0] sum_d;
    logic                  overflow_d;
    logic [CNT_W-1:0]      op_count_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_co;

    adder_nbit #(
        .WIDTH(DATA_WIDTH)
    ) u_adder (
        .a        (sum),
        .b        (data_in),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_co)
    );

    assign cnt_inc = op_count + CNT_W'(1);

    // State register plus registered datapath and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sum        <= '0;
            overflow   <= 1'b0;
            op_count   <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            state      <= next_state;
            sum        <= sum_d;
            overflow   <= overflow_d;
            op_count   <= op_count_d;
            done       <= (next_state == DONE);
            busy       <= (next_state == ACCUM);
            data_ready <= (next_state == ACCUM);
        end
    end

    // Next-state and next-register values
    always_comb begin
        next_state = state;
        sum_d      = sum;
        overflow_d = overflow;
        op_count_d = op_count;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACCUM;
                    sum_d      = '0;
                    overflow_d = 1'b0;
                    op_count_d = '0;
                end
            end
            ACCUM: begin
                if (data_valid) begin
`ifdef ACCUM_SATURATE_EN
                    sum_d      = add_co ? '1 : add_sum;
`else
                    sum_d      = add_sum;
`endif
                    overflow_d = overflow | add_co;
                    op_count_d = cnt_inc;
                    if (cnt_inc == CNT_W'(NUM_OPERANDS)) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    next_state = ACCUM;
                    sum_d      = '0;
                    overflow_d = 1'b0;
                    op_count_d = '0;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed table-driven bench for adder_accumulator (DATA_WIDTH=4, NUM_OPERANDS=4).
`timescale 1ns/1ps
module tb_adder_accumulator;

    localparam int unsigned DW = 4;
    localparam int unsigned NO = 4;
    localparam int unsigned CW = $clog2(NO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_ready;
    logic [DW-1:0] sum;
    logic          overflow;
    logic          done;
    logic          busy;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    adder_accumulator #(
        .DATA_WIDTH   (DW),
        .NUM_OPERANDS (NO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (data_ready),
        .sum        (sum),
        .overflow   (overflow),
        .done       (done),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] ops [NO];
        logic [DW-1:0] sum_wrap;
        logic [DW-1:0] sum_sat;
        logic          ovf;
    } pass_vec_t;

    pass_vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pick_sum(input pass_vec_t v);
`ifdef ACCUM_SATURATE_EN
        return v.sum_sat;
`else
        return v.sum_wrap;
`endif
    endfunction

    task automatic begin_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(data_ready), 32'd1);
        check("start_sum_clr", 32'(sum), 32'd0);
        check("start_cnt_clr", 32'(op_count), 32'd0);
    endtask

    task automatic accept(input logic [DW-1:0] v);
        data_valid = 1'b1;
        data_in    = v;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{ops: '{4'd1, 4'd2, 4'd3, 4'd4},   sum_wrap: 4'd10, sum_sat: 4'd10, ovf: 1'b0};
        vecs[1] = '{ops: '{4'd15, 4'd1, 4'd0, 4'd0},  sum_wrap: 4'd0,  sum_sat: 4'd15, ovf: 1'b1};
        vecs[2] = '{ops: '{4'd8, 4'd8, 4'd8, 4'd8},   sum_wrap: 4'd0,  sum_sat: 4'd15, ovf: 1'b1};
        vecs[3] = '{ops: '{4'd3, 4'd0, 4'd7, 4'd2},   sum_wrap: 4'd12, sum_sat: 4'd12, ovf: 1'b0};
        vecs[4] = '{ops: '{4'd15, 4'd0, 4'd0, 4'd0},  sum_wrap: 4'd15, sum_sat: 4'd15, ovf: 1'b0};

        // Asynchronous reset before any clock edge
        #2;
        rst = 1'b1;
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_cnt", 32'(op_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle_ready", 32'(data_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven full-rate passes
        for (int p = 0; p < 5; p++) begin
            begin_pass();
            for (int i = 0; i < int'(NO); i++) begin
                accept(vecs[p].ops[i]);
                check("cnt_step", 32'(op_count), 32'(i + 1));
                check("done_timing", 32'(done), (i == int'(NO) - 1) ? 32'd1 : 32'd0);
            end
            check("pass_sum", 32'(sum), 32'(pick_sum(vecs[p])));
            check("pass_ovf", 32'(overflow), 32'(vecs[p].ovf));
            check("pass_busy", 32'(busy), 32'd0);
            check("pass_ready", 32'(data_ready), 32'd0);
            tick();
            check("done_pulse_end", 32'(done), 32'd0);
            check("idle_hold_sum", 32'(sum), 32'(pick_sum(vecs[p])));
        end

        // Bubbles mid-pass: 5,5,-,-,3,1
        begin_pass();
        accept(4'd5);
        accept(4'd5);
        tick();
        tick();
        check("bubble_cnt", 32'(op_count), 32'd2);
        check("bubble_sum", 32'(sum), 32'd10);
        check("bubble_done", 32'(done), 32'd0);
        accept(4'd3);
        check("bubble_done3", 32'(done), 32'd0);
        accept(4'd1);
        check("bubble_done4", 32'(done), 32'd1);
        check("bubble_final", 32'(sum), 32'd14);
        tick();
        accept(4'd7);
        check("idle_valid_ignored", 32'(sum), 32'd14);
        check("idle_valid_cnt", 32'(op_count), 32'd4);

        // Reset mid-pass, then a fresh pass
        begin_pass();
        accept(4'd2);
        accept(4'd2);
        check("pre_rst_sum", 32'(sum), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cnt", 32'(op_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(data_ready), 32'd0);
        begin_pass();
        for (int i = 0; i < int'(NO); i++) accept(4'd2);
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_sum", 32'(sum), 32'd8);
        tick();

        // start ignored in ACCUM; start held in DONE gives back-to-back pass
        begin_pass();
        accept(4'd15);
        start = 1'b1;
        accept(4'd1);
        start = 1'b0;
        check("start_ignored_cnt", 32'(op_count), 32'd2);
        check("start_ignored_busy", 32'(busy), 32'd1);
        accept(4'd1);
        accept(4'd1);
        check("b2b_done", 32'(done), 32'd1);
`ifdef ACCUM_SATURATE_EN
        check("b2b_sum", 32'(sum), 32'd15);
`else
        check("b2b_sum", 32'(sum), 32'd2);
`endif
        check("b2b_ovf", 32'(overflow), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_sum_clr", 32'(sum), 32'd0);
        check("b2b_ovf_clr", 32'(overflow), 32'd0);
        check("b2b_cnt_clr", 32'(op_count), 32'd0);
        for (int i = 0; i < int'(NO); i++) accept(4'(i));
        check("b2b_second_sum", 32'(sum), 32'd6);
        check("b2b_second_done", 32'(done), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
